// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner codes
// and the legal range of the memory read latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic OWN_CORE   = 1'b0;
  localparam logic OWN_LOADER = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way picker for the memory arbiter. Tie policy is selected
// by MEM_ARB_RR_EN: round-robin when defined, fixed core priority otherwise.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
  input  logic last_owner,
  input  logic rr_en,
  output logic winner,
  output logic valid
);

  logic tie_winner;

`ifdef MEM_ARB_RR_EN
  // On a tie, serve whichever port was not served last.
  assign tie_winner = rr_en ? ~last_owner : OWN_CORE;
`else
  logic unused_rr;
  assign tie_winner = OWN_CORE;
  assign unused_rr  = last_owner ^ rr_en;
`endif

  always_comb begin
    valid  = c_req | l_req;
    winner = OWN_CORE;
    if (c_req && l_req) begin
      winner = tie_winner;
    end else if (l_req) begin
      winner = OWN_LOADER;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port unified memory between the core and the
// loader/debug port. Tie policy: MEM_ARB_RR_EN (see arb_pick2).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req and its command stable until gnt; gnt
  // is a one-cycle pulse in IDLE and a req still high afterwards is a new
  // request. rvalid is a one-cycle pulse; rdata holds until the next read.

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT=%0d outside legal range", RD_LAT);
  end

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       cmd_we;
  logic       pick_winner;
  logic       pick_valid;
  logic       grant;

  arb_pick2 u_pick (
    .c_req      (c_req),
    .l_req      (l_req),
    .last_owner (owner),
    .rr_en      (1'b1),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign grant     = (state == IDLE) && pick_valid;
  assign c_gnt     = grant && (pick_winner == OWN_CORE);
  assign l_gnt     = grant && (pick_winner == OWN_LOADER);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && cmd_we;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      cmd_we    <= 1'b0;
      owner     <= OWN_LOADER;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_rvalid  <= 1'b0;
      l_rvalid  <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
    end else begin
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= pick_winner;
            state <= ISSUE;
            if (pick_winner == OWN_LOADER) begin
              mem_addr  <= l_addr;
              mem_wdata <= l_wdata;
              cmd_we    <= l_we;
            end else begin
              mem_addr  <= c_addr;
              mem_wdata <= c_wdata;
              cmd_we    <= c_we;
            end
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state <= IDLE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Count 1 marks the cycle in which mem_rdata is valid.
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            if (owner == OWN_CORE) begin
              c_rdata  <= mem_rdata;
              c_rvalid <= 1'b1;
            end else begin
              l_rdata  <= mem_rdata;
              l_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with RD_LAT=2 and a small
// pipelined memory model. Tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic          c_req, c_we, l_req, l_we;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // memory model: 256 words, read data valid LAT cycles after mem_en
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [LAT];
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= {24'hC0FFEE, 8'(i)};
      mem[8'h10] <= 32'hDEADBEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'hBADBAD00;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic core_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
    c_req = 1; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic ldr_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
    l_req = 1; l_we = we; l_addr = a; l_wdata = d;
  endtask

  int cnt;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 1);
    check("rst_state", 32'(state_dbg), 0);
    check("rst_mem_en", 32'({mem_en, mem_we}), 0);
    check("rst_gnt_rvalid", 32'({c_gnt, l_gnt, c_rvalid, l_rvalid}), 0);
    reset = 1'b0;

    // core read 0x10
    cyc(); core_cmd(0, 32'h10, 0);
    @(negedge clk);
    check("rd_c_gnt", 32'({l_gnt, c_gnt}), 32'b01);
    cyc(); c_req = 0;
    @(negedge clk);
    check("rd_mem_en", 32'({mem_en, mem_we}), 32'b10);
    check("rd_mem_addr", mem_addr, 32'h10);
    check("rd_state_issue", 32'(state_dbg), 1);
    cyc(); @(negedge clk);
    check("rd_wait_busy", 32'({busy, mem_en}), 32'b10);
    cyc(); @(negedge clk);
    check("rd_no_early_rvalid", 32'(c_rvalid), 0);
    cyc(); @(negedge clk);
    check("rd_c_rvalid", 32'(c_rvalid), 1);
    check("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    check("rd_l_rvalid", 32'(l_rvalid), 0);
    check("rd_idle", 32'(busy), 0);

    // loader write 0x20 <- 0x1234
    cyc(); ldr_cmd(1, 32'h20, 32'h1234);
    @(negedge clk);
    check("wr_l_gnt", 32'({l_gnt, c_gnt}), 32'b10);
    cyc(); l_req = 0;
    @(negedge clk);
    check("wr_mem_en_we", 32'({mem_en, mem_we}), 32'b11);
    check("wr_mem_addr", mem_addr, 32'h20);
    check("wr_mem_wdata", mem_wdata, 32'h1234);
    cyc(); @(negedge clk);
    check("wr_busy_done", 32'(busy), 0);
    check("wr_no_rvalid", 32'({c_rvalid, l_rvalid}), 0);
    check("wr_mem_written", mem[8'h20], 32'h1234);

    // both ports hold write requests
`ifdef MEM_ARB_RR_EN
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    cyc();
    core_cmd(1, 32'h50, 32'hC0);
    ldr_cmd(1, 32'h54, 32'hD0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        if (exp_q.size() == 0) check("tie_q_underflow", 1, 0);
        else check($sformatf("tie_gnt%0d", i / 2), 32'({l_gnt, c_gnt}), 32'(exp_q.pop_front()));
      end else begin
        check($sformatf("tie_nognt%0d", i), 32'({l_gnt, c_gnt}), 0);
      end
      cyc();
    end
    c_req = 0; l_req = 0;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    check("tie_owner", 32'(owner), 1);
`else
    check("tie_owner", 32'(owner), 0);
`endif

    // back-to-back core reads: 0x30 then 0x34
    cyc(); core_cmd(0, 32'h30, 0);
    @(negedge clk);
    check("b2b_gnt1", 32'(c_gnt), 1);
    cyc(); c_addr = 32'h34;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b_hold%0d", k), 32'(c_gnt), 0);
      cyc();
    end
    @(negedge clk);
    check("b2b_gnt2_with_rvalid", 32'({c_gnt, c_rvalid}), 32'b11);
    check("b2b_rdata1", c_rdata, 32'hC0FFEE30);
    cyc(); c_req = 0;
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("b2b_stable%0d", k), {c_rdata[31:1], c_rvalid}, {32'hC0FFEE30 >> 1, 1'b0});
      cyc();
    end
    @(negedge clk);
    check("b2b_rvalid2", 32'(c_rvalid), 1);
    check("b2b_rdata2", c_rdata, 32'hC0FFEE34);

    // reset during WAIT of a loader read
    cyc(); ldr_cmd(0, 32'h20, 0);
    @(negedge clk);
    check("rst_mid_l_gnt", 32'(l_gnt), 1);
    cyc(); l_req = 0;
    cyc();
    reset = 1'b1;
    #1;
    check("rst_mid_busy_en", 32'({busy, mem_en, mem_we}), 0);
    check("rst_mid_rdata", c_rdata | l_rdata, 0);
    check("rst_mid_cmd", mem_addr | mem_wdata, 0);
    check("rst_mid_owner", 32'(owner), 1);
    cyc(); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (l_rvalid) cnt++;
      cyc();
    end
    check("rst_mid_no_l_rvalid", 32'(cnt), 0);
    core_cmd(0, 32'h10, 0);
    @(negedge clk);
    check("post_rst_gnt", 32'(c_gnt), 1);
    cyc(); c_req = 0;
    repeat (3) cyc();
    @(negedge clk);
    check("post_rst_rvalid", 32'({c_rvalid, l_rvalid}), 32'b10);
    check("post_rst_rdata", c_rdata, 32'hDEADBEEF);

    // loader cancels while core owns memory
    cyc(); core_cmd(1, 32'h40, 32'h7);
    cnt = 0;
    @(negedge clk);
    check("cancel_c_gnt", 32'(c_gnt), 1);
    cyc(); c_req = 0; ldr_cmd(1, 32'h44, 32'h99);
    @(negedge clk);
    if (mem_en) cnt++;
    check("cancel_no_l_gnt_busy", 32'(l_gnt), 0);
    cyc(); l_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_en) cnt++;
      check($sformatf("cancel_no_l_gnt%0d", i), 32'(l_gnt), 0);
      cyc();
    end
    check("cancel_one_access", 32'(cnt), 1);
    check("cancel_mem_untouched", mem[8'h44], 32'hC0FFEE44);
    check("cancel_core_write", mem[8'h40], 32'h7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
